// File: rtl/dds_par_pkg.sv
// Shared types and constants for the DDS 8-bit parallel-port sequencer.
// The address byte carries the read/write flag in its top bit.
package dds_par_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_A_HI,
    S_D_LO,
    S_D_HI,
    S_HOLD,
    S_IOUP
  } state_t;

  localparam int RW_BIT  = 7;
  localparam int ADDR_W  = 7;
  localparam int CNT_MIN = 1;
  localparam int CNT_MAX = 255;

  function automatic logic [7:0] addr_byte(
    input logic              rw,
    input logic [ADDR_W-1:0] addr
  );
    logic [7:0] b;
    b = '0;
    b[ADDR_W-1:0] = addr;
    b[RW_BIT] = rw;
    return b;
  endfunction

  function automatic bit cnt_ok(input int v);
    return (v >= CNT_MIN) && (v <= CNT_MAX);
  endfunction

endpackage

// File: rtl/dds_phase_timer.sv
// Loadable 8-bit down-counter with zero flag.
// Shared by the PCLK phase and IO_update timing.
module dds_phase_timer (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/dds_par_ctrl.sv
// DDS parallel-port sequencer: single register read/write plus
// IO_update generation, all pins driven from registers.
module dds_par_ctrl
  import dds_par_pkg::*;
#(
  parameter int PCLK_HALF  = 4,
  parameter int IOUP_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       cmd_update,
  input  logic       upd_req,
  output logic       done,
  output logic [7:0] rsp_data,
  output logic       dds_csn,
  output logic       dds_rwn,
  output logic       dds_pclk,
  output logic [7:0] dds_data_out,
  input  logic [7:0] dds_data_in,
  output logic       dds_read_en,
  output logic       dds_ioup
);

  if (!cnt_ok(PCLK_HALF)) begin : g_bad_pclk
    $fatal(1, "PCLK_HALF out of range 1..255");
  end
  if (!cnt_ok(IOUP_WIDTH)) begin : g_bad_ioup
    $fatal(1, "IOUP_WIDTH out of range 1..255");
  end

  localparam logic [7:0] PH_LD = 8'(PCLK_HALF - 1);
  localparam logic [7:0] IU_LD = 8'(IOUP_WIDTH - 1);

  state_t     state;
  logic       rw_q;
  logic       upd_q;
  logic [6:0] addr_q;
  logic [7:0] data_q;
  logic       pend;
  logic       pend_clr;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_zero;

  dds_phase_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // IDLE reloads every cycle so the count is fresh on departure
  always_comb begin
    tmr_val  = PH_LD;
    tmr_load = tmr_zero;
    unique case (state)
      S_IDLE: begin
        tmr_load = 1'b1;
        if (!cmd_valid) tmr_val = IU_LD;
      end
      S_HOLD: begin
        if (!rw_q && upd_q) tmr_val = IU_LD;
      end
      default: ;
    endcase
  end

  assign pend_clr  = (state == S_IDLE) && !cmd_valid && pend;
  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= 1'b0;
    end else begin
      pend <= upd_req | (pend & ~pend_clr);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rw_q         <= 1'b0;
      upd_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      done         <= 1'b0;
      rsp_data     <= '0;
      dds_csn      <= 1'b1;
      dds_rwn      <= 1'b1;
      dds_pclk     <= 1'b0;
      dds_data_out <= '0;
      dds_read_en  <= 1'b0;
      dds_ioup     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rw_q         <= cmd_rw;
            upd_q        <= cmd_update;
            addr_q       <= cmd_addr;
            data_q       <= cmd_data;
            dds_csn      <= 1'b0;
            dds_pclk     <= 1'b0;
            dds_rwn      <= cmd_rw;
            dds_data_out <= addr_byte(cmd_rw, cmd_addr);
            dds_read_en  <= 1'b0;
            state        <= S_SETUP;
          end else if (pend) begin
            dds_ioup <= 1'b1;
            state    <= S_IOUP;
          end
        end
        S_SETUP: begin
          if (tmr_zero) begin
            dds_pclk <= 1'b1;
            state    <= S_A_HI;
          end
        end
        S_A_HI: begin
          if (tmr_zero) begin
            dds_pclk <= 1'b0;
            if (rw_q) dds_read_en  <= 1'b1;
            else      dds_data_out <= data_q;
            state <= S_D_LO;
          end
        end
        S_D_LO: begin
          if (tmr_zero) begin
            dds_pclk <= 1'b1;
            state    <= S_D_HI;
          end
        end
        S_D_HI: begin
          if (tmr_zero) begin
            if (rw_q) rsp_data <= dds_data_in;
            dds_pclk <= 1'b0;
            dds_csn  <= 1'b1;
            dds_rwn  <= 1'b1;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tmr_zero) begin
            dds_read_en <= 1'b0;
            if (!rw_q && upd_q) begin
              dds_ioup <= 1'b1;
              state    <= S_IOUP;
            end else begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_IOUP: begin
          if (tmr_zero) begin
            dds_ioup <= 1'b0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_par_ctrl.sv
// Bench for dds_par_ctrl: scoreboard on done/rsp_data plus
// per-access pin waveform checks and a PCLK_HALF=1 instance.
module tb_dds_par_ctrl;

  localparam int P  = 4;
  localparam int IW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_update = 1'b0;
  logic       upd_req = 1'b0;
  logic       done;
  logic [7:0] rsp_data;
  logic       dds_csn, dds_rwn, dds_pclk;
  logic [7:0] dds_data_out;
  logic [7:0] dds_data_in;
  logic       dds_read_en, dds_ioup;
  logic [7:0] dds_val = '0;

  assign dds_data_in = dds_read_en ? dds_val : 8'h00;

  dds_par_ctrl #(.PCLK_HALF(P), .IOUP_WIDTH(IW)) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_update   (cmd_update),
    .upd_req      (upd_req),
    .done         (done),
    .rsp_data     (rsp_data),
    .dds_csn      (dds_csn),
    .dds_rwn      (dds_rwn),
    .dds_pclk     (dds_pclk),
    .dds_data_out (dds_data_out),
    .dds_data_in  (dds_data_in),
    .dds_read_en  (dds_read_en),
    .dds_ioup     (dds_ioup)
  );

  logic       p1_valid = 1'b0;
  logic       p1_ready, p1_done, p1_csn, p1_rwn, p1_pclk;
  logic       p1_ren, p1_ioup;
  logic [7:0] p1_rsp, p1_dout;

  dds_par_ctrl #(.PCLK_HALF(1), .IOUP_WIDTH(2)) u_p1 (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (p1_valid),
    .cmd_ready    (p1_ready),
    .cmd_rw       (1'b0),
    .cmd_addr     (7'h2A),
    .cmd_data     (8'h5A),
    .cmd_update   (1'b0),
    .upd_req      (1'b0),
    .done         (p1_done),
    .rsp_data     (p1_rsp),
    .dds_csn      (p1_csn),
    .dds_rwn      (p1_rwn),
    .dds_pclk     (p1_pclk),
    .dds_data_out (p1_dout),
    .dds_data_in  (8'h00),
    .dds_read_en  (p1_ren),
    .dds_ioup     (p1_ioup)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         done_cyc;
    logic [7:0] rsp;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_rsp = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rstn && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 0);
      end else begin
        e = sb.pop_front();
        check("done_cyc", cyc, e.done_cyc);
        check("rsp_data", 32'(rsp_data), 32'(e.rsp));
      end
    end
  end

  task automatic push_exp(input int dc);
    exp_t e;
    e.done_cyc = dc;
    e.rsp      = last_rsp;
    sb.push_back(e);
  endtask

  task automatic send(input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input logic u,
                      input logic [7:0] rv, output int acc);
    int n = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_rw     = rw;
    cmd_addr   = a;
    cmd_data   = d;
    cmd_update = u;
    if (rw) dds_val = rv;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 200), 1);
    acc = cyc + 1;
    if (rw) last_rsp = rv;
    push_exp(acc + 5 * P + ((u && !rw) ? IW : 0));
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_rw     = ~rw;
    cmd_addr   = ~a;
    cmd_data   = ~d;
    cmd_update = 1'b0;
  endtask

  task automatic watch(input logic rw, input logic [6:0] a,
                       input logic [7:0] d, input logic u,
                       input string t);
    int   bus_err = 0, ctl_err = 0, ren_err = 0;
    int   rises = 0, ioup_hi = 0, clash = 0;
    int   n = 5 * P + ((u && !rw) ? IW : 0) + 1;
    logic prev_pclk = 1'b0;
    logic seen = 1'b0;
    logic drv = 1'b0;
    for (int i = 0; i < n; i++) begin
      int         ph;
      logic [7:0] eb;
      ph = i / P;
      @(negedge clk);
      if (i < 5 * P) begin
        eb = (ph >= 2 && !rw) ? d : {rw, a};
        if (dds_data_out !== eb) bus_err++;
        if (dds_csn !== (ph == 4) || dds_pclk !== (ph == 1 || ph == 3) ||
            dds_rwn !== ((ph == 4) ? 1'b1 : rw)) ctl_err++;
        if (dds_read_en !== (rw && ph >= 2)) ren_err++;
      end
      if (!dds_csn && dds_pclk && !prev_pclk) rises++;
      prev_pclk = dds_pclk;
      if (dds_ioup) ioup_hi++;
      if (dds_csn) begin
        seen = 1'b0;
        drv  = 1'b0;
      end else if (dds_pclk) begin
        seen = 1'b1;
      end else if (seen && dds_rwn) begin
        drv = 1'b1;
      end
      if (drv && !dds_read_en) clash++;
    end
    check({t, "_bus"}, bus_err, 0);
    check({t, "_ctl"}, ctl_err, 0);
    check({t, "_read_en"}, ren_err, 0);
    check({t, "_pclk_rises"}, rises, 2);
    check({t, "_ioup_cycles"}, ioup_hi, (u && !rw) ? IW : 0);
    check({t, "_contention"}, clash, 0);
  endtask

  task automatic drain(input string t);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({t, "_drain"}, sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_pins(input string t);
    check({t, "_ctl"},
          32'({cmd_ready, done, dds_csn, dds_rwn, dds_pclk,
               dds_read_en, dds_ioup}), 32'(7'b1011000));
    check({t, "_bus"}, 32'(dds_data_out), 0);
    check({t, "_rsp"}, 32'(rsp_data), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_r, acc_w;
    int accs[$];
    int tog_err, dones;
    logic prev_csn, prev_pclk;

    repeat (2) @(negedge clk);
    check_reset_pins("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    send(1'b0, 7'h05, 8'hA3, 1'b0, 8'h00, acc);
    watch(1'b0, 7'h05, 8'hA3, 1'b0, "wr");
    drain("wr");

    send(1'b1, 7'h11, 8'h00, 1'b0, 8'h5C, acc);
    watch(1'b1, 7'h11, 8'h00, 1'b0, "rd");
    drain("rd");

    send(1'b0, 7'h22, 8'h7E, 1'b1, 8'h00, acc);
    watch(1'b0, 7'h22, 8'h7E, 1'b1, "wr_upd");
    drain("wr_upd");

    send(1'b1, 7'h33, 8'h00, 1'b0, 8'hC6, acc_r);
    repeat (3) @(negedge clk);
    upd_req = 1'b1;
    @(negedge clk);
    upd_req = 1'b0;
    send(1'b0, 7'h44, 8'h19, 1'b0, 8'h00, acc_w);
    check("b2b_accept_cyc", acc_w, acc_r + 5 * P + 1);
    push_exp(acc_w + 5 * P + IW + 1);
    drain("pend_upd");

    send(1'b0, 7'h55, 8'h66, 1'b1, 8'h00, acc);
    repeat (2 * P + 2) @(negedge clk);
    check("abort_in_dlo_bus", 32'(dds_data_out), 32'h66);
    #2;
    rstn = 1'b0;
    sb.delete();
    last_rsp = '0;
    #1;
    check_reset_pins("abort");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    send(1'b1, 7'h7F, 8'h00, 1'b0, 8'hE1, acc);
    watch(1'b1, 7'h7F, 8'h00, 1'b0, "post_rst");
    drain("post_rst");

    tog_err   = 0;
    dones     = 0;
    prev_csn  = 1'b1;
    prev_pclk = 1'b0;
    @(negedge clk);
    p1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (p1_ready) accs.push_back(cyc + 1);
      if (p1_done) dones++;
      if (!p1_csn && !prev_csn && p1_pclk === prev_pclk) tog_err++;
      prev_csn  = p1_csn;
      prev_pclk = p1_pclk;
    end
    p1_valid = 1'b0;
    check("p1_accepts", accs.size(), 4);
    for (int i = 1; i < accs.size(); i++)
      check("p1_gap", accs[i] - accs[i-1], 6);
    check("p1_dones", dones, 3);
    check("p1_pclk_toggle", tog_err, 0);
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_par_ctrl.md
# dds_par_ctrl

Sequencer for the DDS 8-bit parallel programming port. Accepts single-register read/write commands over a valid/ready interface from the PS-side register block. Generates the CSn/RWn/PCLK/bus-direction/IO_update waveform on the DDS pins and returns read data. Sits between the AXI register slave and the top-level DDS pin assignments (DDS_CSn, DDS_RWn, DDS_PCLK, DDS_DataOut/In, DDS_ReadEn, DDS_IOup).

## Interface
- PCLK_HALF, 4: clk cycles per PCLK half-period; legal range 1..255.
- IOUP_WIDTH, 8: clk cycles IO_update is held high; legal range 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  7  DDS register address.
- cmd_data  in  8  write data; ignored for reads.
- cmd_update  in  1  pulse IO_update after a write.
- upd_req  in  1  single-cycle request for a standalone IO_update.
- done  out  1  one-cycle pulse when a command or standalone update completes.
- rsp_data  out  8  read data; valid when done is high after a read; holds until the next read completes.
- dds_csn  out  1  chip select, active low.
- dds_rwn  out  1  1 = read, 0 = write.
- dds_pclk  out  1  port clock; the DDS samples on the rising edge.
- dds_data_out  out  8  bus drive value.
- dds_data_in  in  8  bus sample value.
- dds_read_en  out  1  1 = FPGA releases the bus (tristate).
- dds_ioup  out  1  IO_update.

## Operation
- Handshake: a command is accepted when cmd_valid && cmd_ready. The rw, addr, data and update fields are latched at acceptance. The host may change its inputs afterwards.
- FSM: IDLE, SETUP, A_HI, D_LO, D_HI, HOLD, IOUP.
- Each state from SETUP through HOLD lasts exactly PCLK_HALF cycles. A down-counter is loaded with PCLK_HALF-1 on entry to each state.
- SETUP: dds_csn=0, dds_pclk=0, dds_rwn=rw, dds_data_out={rw, addr}, dds_read_en=0.
- A_HI: dds_pclk=1; the address byte is held.
- D_LO: dds_pclk=0.
  - Write: dds_data_out=data.
  - Read: dds_read_en=1.
- D_HI: dds_pclk=1.
  - Read: dds_data_in is registered into rsp_data in the last cycle of D_HI.
- HOLD: dds_pclk=0, dds_csn=1.
  - dds_read_en stays at its D_HI value to avoid bus contention and drops to 0 on leaving HOLD.
  - dds_rwn returns to 1.
- After HOLD:
  - Write with update=1: go to IOUP, with dds_ioup=1 for IOUP_WIDTH cycles, then IDLE.
  - All other commands: go directly to IDLE.
- Standalone update:
  - An upd_req pulse sets a pending flag in any state.
  - In IDLE with the flag set and cmd_valid low: clear the flag and go to IOUP.
- Priority in IDLE: cmd_valid beats the pending update. The update then runs after that command.
- upd_req arriving in the same cycle the flag is cleared leaves the flag set (set wins).
- done:
  - Pulses in the first IDLE cycle after HOLD (no update) or after IOUP.
  - cmd_ready is high in that same cycle, so back-to-back acceptance is allowed.
- Reset values:
  - State IDLE, cmd_ready=1, done=0, rsp_data=0.
  - dds_csn=1, dds_rwn=1, dds_pclk=0, dds_data_out=0, dds_read_en=0, dds_ioup=0.
  - Pending flag=0.
- Reset mid-transfer aborts immediately to the reset values. No partial completion is reported.
- All pin outputs are registered, with no combinational path from inputs to pins. cmd_ready is decoded from the state register.

## Timing
- Acceptance at edge T0 gives SETUP in cycles T0+1 .. T0+P, where P = PCLK_HALF.
- HOLD ends at T0+5P.
- done is high in cycle T0+5P+1, or T0+5P+IOUP_WIDTH+1 when IO_update runs.
- Standalone update: pending flag set to done in IOUP_WIDTH+1 cycles from IDLE entry into IOUP.
- With P=4 there are 5P=20 cycles of PCLK activity per access. The PCLK period is 2P.
- rsp_data changes only in the last cycle of D_HI for reads. It is stable while done is high.

## Structure
- Package dds_par_pkg holds:
  - the state enum;
  - the address byte layout constant (bit 7 = rw, bits 6:0 = addr);
  - parameter range checks.
- One sub-module, dds_phase_timer: an 8-bit loadable down-counter with a zero flag. It is shared by the phase and IOUP timing.

## Test plan
- Write addr 0x05, data 0xA3, update=0, P=4:
  - the bus shows 0x05 during SETUP/A_HI, then 0xA3 during D_LO/D_HI;
  - exactly 2 PCLK rising edges occur with CSn low;
  - done is high at T0+21 and dds_ioup never rises.
- Read addr 0x11 with the DDS model driving 0x5C when read_en=1:
  - the bus shows 0x91;
  - read_en is high from D_LO through HOLD;
  - rsp_data=0x5C with done at T0+21;
  - there is no cycle where both sides drive the bus.
- Write with update=1, IOUP_WIDTH=8: dds_ioup is high for exactly 8 cycles after HOLD, and done is high at T0+29.
- upd_req pulsed during a read, with cmd_valid held for a second write:
  - the read completes, then the write is accepted in the done cycle;
  - the standalone IOUP follows the write;
  - two done pulses occur in total after the read's done.
- rstn asserted during D_LO of a write:
  - all outputs take their reset values asynchronously;
  - no done pulse;
  - the next command after release completes normally.
- P=1 corner case: a back-to-back write stream gives one access every 6 cycles, with PCLK toggling every cycle during access.
